mux4_scan_ctrl: RTL and testbench
=================================

Name: mux4_scan_ctrl

Overview:
- Sequential scan controller that sits directly upstream of the 4:1 single-bit mux.
- Drives the mux select `sel[1:0]` through channels 0..3, dwelling DIV cycles per channel.
- Samples the mux output fed back on `din` at the end of each dwell and assembles the four samples into a 4-bit frame.
- Signals frame completion with a one-cycle valid pulse.

Parameters:
- DIV, 4, dwell cycles per channel; legal range 1..2^CNT_W.
- CNT_W, 8, prescaler counter width; must represent DIV-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk at system level.
- start  input  1  request one scan; sampled in IDLE and DONE only.
- hold  input  1  freezes the prescaler and sel while in SCAN; ignored elsewhere.
- din  input  1  mux output for the currently selected channel.
- sel  output  2  select to the downstream 4:1 mux; registered.
- frame  output  4  last completed frame; frame[k] = sample taken while sel==k.
- frame_vld  output  1  one-cycle pulse; frame is new this cycle.
- busy  output  1  high in SCAN and DONE.

Behaviour:
- Reset (rst_n low, immediate, any state, including mid-scan):
  - sel=2'b00, frame=4'b0000, frame_vld=0, busy=0.
  - State IDLE; prescaler=0; internal shadow bits=0.
- States are IDLE, SCAN and DONE, all registered. sel, frame, frame_vld and busy are registered outputs.
- IDLE:
  - sel=0, busy=0.
  - start=1 at an edge: next state SCAN, prescaler=0, sel=0.
- SCAN:
  - busy=1.
  - Each edge with hold=0: prescaler increments.
  - Each edge with hold=1: prescaler and sel unchanged; no sample is taken.
  - Tick = (prescaler==DIV-1) && hold==0.
  - On tick: shadow[sel] <= din, prescaler <= 0.
    - If sel==3: frame <= {din, shadow[2:0]}, next state DONE, sel unchanged.
    - Else: sel <= sel+1.
  - start is ignored in SCAN.
- DONE (exactly one cycle):
  - frame_vld=1, busy=1.
  - Next edge, start=1: SCAN again, sel=0, prescaler=0. Back-to-back scan with no IDLE gap.
  - Next edge, start=0: IDLE, sel=0.
- din is sampled on the same edge that advances sel, so the downstream mux settles within one cycle of a sel change.
- Latency with DIV=N and no hold:
  - start sampled at edge E0.
  - sel=k during cycles k*N+1 .. (k+1)*N after E0.
  - frame_vld is high in cycle 4N+1 after E0.
  - Each hold cycle in SCAN adds exactly one cycle.
- DIV=1: tick on every non-hold SCAN edge; sel advances 0,1,2,3 on consecutive cycles.
- frame holds its value between DONE pulses. It is not cleared on a new start, only by reset.
- sel never exceeds 3; no wrap from 3 inside SCAN.
- Simultaneous start and hold in IDLE: start wins; hold is ignored.

Decomposition:
- Shared package scan_pkg:
  - State encoding IDLE=2'b00, SCAN=2'b01, DONE=2'b10; code 2'b11 is illegal and recovers to IDLE.
  - Constant NCH=4.
  - Constant SEL_W=2.
- Sub-module scan_div_cnt:
  - Parameterised by DIV and CNT_W.
  - Inputs: clk, rst_n, clr, en (=SCAN && !hold).
  - Output: tick.
  - Owns the prescaler register.
- Top module holds the FSM, sel, shadow and frame registers.

Test Plan:
- Reset: assert rst_n=0 at arbitrary time -> sel=0, frame=0, frame_vld=0, busy=0 without waiting for a clock edge.
- Basic scan, DIV=4:
  - Stimulus: pulse start; din driven 1,0,1,1 while sel=0,1,2,3.
  - Required: sel changes at cycles 5, 9, 13; frame_vld high only in cycle 17; frame=4'b1101; busy high cycles 1..17.
- Hold, DIV=4: assert hold for 3 cycles while sel=2 -> sel stays 2 for 7 cycles; frame_vld moves to cycle 20; frame value unchanged vs. the no-hold run.
- Back-to-back: keep start=1 through DONE -> second scan begins next cycle with sel=0; busy never drops; second frame_vld 17 cycles after the first.
- Reset mid-scan: pull rst_n low while sel=2 -> all outputs zero immediately; after release, start gives a clean scan with frame_vld at cycle 17 and no stale shadow bits.
- DIV=1: pulse start with din=0,1,1,0 per channel -> sel=0,1,2,3 in cycles 1..4; frame_vld in cycle 5; frame=4'b0110.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// The state encoding is fixed so that the unused code 2'b11 falls back to IDLE.
package scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/scan_div_cnt.sv
// Dwell prescaler: counts enabled cycles and flags the last one of each dwell.
// tick is combinational from the count so the top can act on the same edge.
module scan_div_cnt #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan controller driving a 4:1 mux select, sampling the fed-back mux output at
// the end of each dwell and publishing the 4-bit frame with a one-cycle valid.
module mux4_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic             din,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   frame,
  output logic             frame_vld,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   frame_q, frame_d;
  logic [NCH-2:0]   shadow_q, shadow_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

  logic cnt_clr;
  logic cnt_en;
  logic tick;

  // Prescaler is held at zero outside SCAN, so every scan starts a full dwell.
  assign cnt_clr = (state_q != SCAN);
  assign cnt_en  = (state_q == SCAN) && !hold;

  scan_div_cnt #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_div_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (tick && (sel_q == LAST_SEL)) state_d = DONE;
      DONE:    state_d = start ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last channel's sample goes straight into the frame; only the first
  // three channels need a shadow bit.
  always_comb begin
    sel_d   = sel_q;
    frame_d = frame_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (sel_q == LAST_SEL) begin
            frame_d = {din, shadow_q};
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      default: sel_d = '0;
    endcase
    vld_d  = (state_d == DONE);
    busy_d = (state_d == SCAN) || (state_d == DONE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH - 1; gi++) begin : g_shadow
      assign shadow_d[gi] = ((state_q == SCAN) && tick && (sel_q == SEL_W'(gi)))
                            ? din : shadow_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign frame     = frame_q;
  assign frame_vld = vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: one DUT with DIV=4, one with DIV=1, each fed by a
// behavioural 4:1 mux; expectations come from a dwell-counting model.
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start4 = 1'b0, hold4 = 1'b0, din4;
  logic       start1 = 1'b0, hold1 = 1'b0, din1;
  logic [3:0] bits4 = 4'b0000, bits1 = 4'b0000;
  logic [1:0] sel4, sel1;
  logic [3:0] frame4, frame1;
  logic       vld4, vld1, busy4, busy1;

  always #5 clk = ~clk;

  // The downstream mux being scanned: each channel carries a constant bit.
  assign din4 = bits4[sel4];
  assign din1 = bits1[sel1];

  mux4_scan_ctrl #(.DIV(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .hold(hold4), .din(din4),
    .sel(sel4), .frame(frame4), .frame_vld(vld4), .busy(busy4)
  );

  mux4_scan_ctrl #(.DIV(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1), .din(din1),
    .sel(sel1), .frame(frame1), .frame_vld(vld1), .busy(busy1)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         which;
    logic [3:0] bits;
    logic [63:0] hmask;
    int         exp_vld;
    logic [3:0] exp_frame;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int which, input logic s, input logic h);
    if (which == 4) begin start4 = s; hold4 = h; end
    else            begin start1 = s; hold1 = h; end
  endtask

  function automatic logic [1:0] o_sel(input int which);
    return (which == 4) ? sel4 : sel1;
  endfunction
  function automatic logic [3:0] o_frame(input int which);
    return (which == 4) ? frame4 : frame1;
  endfunction
  function automatic logic o_vld(input int which);
    return (which == 4) ? vld4 : vld1;
  endfunction
  function automatic logic o_busy(input int which);
    return (which == 4) ? busy4 : busy1;
  endfunction

  // Entered at a negedge; start is sampled at the next posedge (cycle 0).
  // Model: in cycle c, sel = (non-hold SCAN cycles before c) / DIV, and the
  // frame is complete once 4*DIV non-hold cycles have elapsed.
  // Leaves at the negedge of the DONE cycle, with start = keep.
  task automatic run_scan(input int which, input logic [3:0] bits, input logic [63:0] hmask,
                          input bit noise, input bit keep, output int vld_cycle);
    int   div;
    int   nh;
    bit   done;
    logic s, h;
    div = which;
    nh = 0;
    done = 0;
    vld_cycle = 0;
    if (which == 4) bits4 = bits; else bits1 = bits;
    set_in(which, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c <= 300 && !done; c++) begin
      h = (c < 64) ? hmask[c] : 1'b0;
      if (nh == 4 * div) s = keep;
      else               s = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      set_in(which, s, h);
      @(negedge clk);
      chk("busy", 32'(o_busy(which)), 32'd1);
      chk("frame_vld", 32'(o_vld(which)), 32'(nh == 4 * div));
      if (o_vld(which) && vld_cycle == 0) vld_cycle = c;
      if (nh == 4 * div) begin
        chk("frame", 32'(o_frame(which)), 32'(bits));
        done = 1;
      end else begin
        chk("sel", 32'(o_sel(which)), 32'(nh / div));
        if (!h) nh++;
        @(posedge clk); #1;
      end
    end
    if (!done) chk("scan_timeout", 32'd0, 32'd1);
    $display("scan DIV=%0d bits=%b hold=%h frame_vld@cycle %0d frame=%b",
             div, bits, hmask, vld_cycle, o_frame(which));
  endtask

  // One IDLE cycle after a scan: outputs idle, frame retained.
  task automatic idle_gap(input int which, input logic [3:0] bits);
    set_in(which, 1'b0, 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", 32'(o_busy(which)), 32'd0);
    chk("idle_vld", 32'(o_vld(which)), 32'd0);
    chk("idle_sel", 32'(o_sel(which)), 32'd0);
    chk("idle_frame", 32'(o_frame(which)), 32'(bits));
  endtask

  vec_t vecs[6];

  initial begin
    int vc, vc2, w, waited;
    logic [3:0] b;
    logic [63:0] m;

    vecs[0] = '{4, 4'b1101, 64'h0,     17, 4'b1101};
    vecs[1] = '{4, 4'b1101, 64'h0E00,  20, 4'b1101};
    vecs[2] = '{1, 4'b0110, 64'h0,      5, 4'b0110};
    vecs[3] = '{1, 4'b1001, 64'h4,      6, 4'b1001};
    vecs[4] = '{4, 4'b0000, 64'h0,     17, 4'b0000};
    vecs[5] = '{4, 4'b1010, 64'h10002, 19, 4'b1010};

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel4), 32'd0);
    chk("rst_frame", 32'(frame4), 32'd0);
    chk("rst_vld", 32'(vld4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].which, vecs[i].bits, vecs[i].hmask, 1'b0, 1'b0, vc);
      chk("vld_cycle", 32'(vc), 32'(vecs[i].exp_vld));
      chk("tbl_frame", 32'(o_frame(vecs[i].which)), 32'(vecs[i].exp_frame));
      idle_gap(vecs[i].which, vecs[i].bits);
    end

    // Back-to-back: start held through DONE, second scan follows immediately.
    run_scan(4, 4'b1011, 64'h0, 1'b0, 1'b1, vc);
    chk("b2b_first_vld", 32'(vc), 32'd17);
    run_scan(4, 4'b0110, 64'h0, 1'b0, 1'b0, vc2);
    chk("b2b_second_vld", 32'(vc2), 32'd17);
    idle_gap(4, 4'b0110);

    // Reset mid-scan while sel==2.
    bits4 = 4'b1111;
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    waited = 0;
    while (sel4 != 2'd2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("wait_sel2", 32'(sel4), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel4), 32'd0);
    chk("midrst_frame", 32'(frame4), 32'd0);
    chk("midrst_vld", 32'(vld4), 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_frame1", 32'(frame1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_scan(4, 4'b0100, 64'h0, 1'b0, 1'b0, vc);
    chk("post_rst_vld", 32'(vc), 32'd17);
    idle_gap(4, 4'b0100);

    // Random scans: random channel data, sparse holds, start noise during SCAN.
    for (int r = 0; r < 16; r++) begin
      w = ($urandom_range(0, 1) == 1) ? 4 : 1;
      b = 4'($urandom_range(0, 15));
      m = {$urandom, $urandom} & {$urandom, $urandom};
      run_scan(w, b, m, 1'b1, 1'b0, vc);
      idle_gap(w, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
